// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO output port with set/clear/toggle aliases
// and a hardware blink engine that periodically XORs MASK into OUT.
//
// Ports:
//   xtal    - clock, all state updates on the rising edge
//   resetn  - asynchronous active-low reset
//   sel     - peripheral selected by the address decoder
//   addr    - register word offset (0 OUT, 1 SET, 2 CLR, 3 TOG,
//             4 PERIOD, 5 MASK, 6 CTRL, 7 reserved)
//   wdata   - write data
//   wmask   - byte write enables; nonzero with sel high is a write
//   rstrb   - one-cycle read strobe
//   rdata   - read data, zero whenever rvalid is low
//   rvalid  - one-cycle pulse marking rdata valid
//   gpio    - pin levels, driven straight from OUT
//
// Blink FSM:
//   state   | meaning
//   S_IDLE  | blink engine stopped, cnt held
//   S_COUNT | cnt counts down; at 0 OUT ^= MASK and cnt reloads PERIOD

module gpio_port #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 24
) (
  input  logic             xtal,
  input  logic             resetn,
  input  logic             sel,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  input  logic             rstrb,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic [WIDTH-1:0] gpio
);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  localparam logic [2:0] A_OUT    = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_TOG    = 3'd3;
  localparam logic [2:0] A_PERIOD = 3'd4;
  localparam logic [2:0] A_MASK   = 3'd5;
  localparam logic [2:0] A_CTRL   = 3'd6;

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] period_q;
  logic [WIDTH-1:0] mask_q;
  logic             blink_en_q;
  logic [CNT_W-1:0] cnt;

  logic             wr_en;
  logic [31:0]      bmask;
  logic [31:0]      wd;
  logic             sw_out_wr;
  logic [WIDTH-1:0] out_sw_nxt;
  logic             period_wr;
  logic [CNT_W-1:0] period_nxt;
  logic [31:0]      rd_mux;

  assign wr_en = sel && (wmask != 4'b0000);
  assign bmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign wd    = wdata & bmask;

  assign sw_out_wr = wr_en && (addr == A_OUT || addr == A_SET ||
                               addr == A_CLR || addr == A_TOG);
  assign period_wr = wr_en && (addr == A_PERIOD);

  // Software view of OUT after this cycle's write; the FSM decides whether
  // it or the blink toggle wins.
  always_comb begin
    out_sw_nxt = out_q;
    case (addr)
      A_OUT:   out_sw_nxt = (out_q & ~bmask[WIDTH-1:0]) | wd[WIDTH-1:0];
      A_SET:   out_sw_nxt = out_q | wd[WIDTH-1:0];
      A_CLR:   out_sw_nxt = out_q & ~wd[WIDTH-1:0];
      A_TOG:   out_sw_nxt = out_q ^ wd[WIDTH-1:0];
      default: out_sw_nxt = out_q;
    endcase
  end

  // Next PERIOD value, also used to reload cnt so a new period takes
  // effect right away instead of after the current count expires.
  always_comb begin
    period_nxt = period_q;
    if (period_wr)
      period_nxt = (period_q & ~bmask[CNT_W-1:0]) | wd[CNT_W-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:    rd_mux[WIDTH-1:0] = out_q;
      A_PERIOD: rd_mux[CNT_W-1:0] = period_q;
      A_MASK:   rd_mux[WIDTH-1:0] = mask_q;
      A_CTRL:   rd_mux[0]         = blink_en_q;
      default:  rd_mux            = '0;
    endcase
  end

  always_ff @(posedge xtal or negedge resetn) begin
    if (!resetn) begin
      period_q   <= '0;
      mask_q     <= '0;
      blink_en_q <= 1'b0;
    end else begin
      period_q <= period_nxt;
      if (wr_en && addr == A_MASK)
        mask_q <= (mask_q & ~bmask[WIDTH-1:0]) | wd[WIDTH-1:0];
      if (wr_en && addr == A_CTRL && wmask[0])
        blink_en_q <= wdata[0];
    end
  end

  always_ff @(posedge xtal or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      if (sw_out_wr)
        out_q <= out_sw_nxt;
      case (state)
        S_IDLE: begin
          if (blink_en_q && period_q != '0) begin
            state <= S_COUNT;
            cnt   <= period_q;
          end
        end
        S_COUNT: begin
          if (!blink_en_q || period_q == '0) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            // A coinciding software write owns OUT; the toggle is dropped.
            if (!sw_out_wr)
              out_q <= out_q ^ mask_q;
            cnt <= period_nxt;
          end else if (period_wr) begin
            cnt <= period_nxt;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge xtal or negedge resetn) begin
    if (!resetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= sel && rstrb;
      rdata  <= (sel && rstrb) ? rd_mux : 32'h0;
    end
  end

  assign gpio = out_q;

endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;

  logic        xtal;
  logic        resetn;
  logic        sel;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rstrb;
  logic [31:0] rdata;
  logic        rvalid;
  logic [15:0] gpio;

  int total;
  int bad;

  gpio_port #(.WIDTH(16), .CNT_W(24)) dut (
    .xtal   (xtal),
    .resetn (resetn),
    .sel    (sel),
    .addr   (addr),
    .wdata  (wdata),
    .wmask  (wmask),
    .rstrb  (rstrb),
    .rdata  (rdata),
    .rvalid (rvalid),
    .gpio   (gpio)
  );

  initial xtal = 1'b0;
  always #5 xtal = ~xtal;

  // Called at a negedge; the write lands on the next posedge and the task
  // returns at the following negedge with the result visible.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; addr = a; wdata = d; wmask = m; rstrb = 1'b0;
    @(negedge xtal);
    sel = 1'b0; wmask = 4'b0000; wdata = 32'h0;
  endtask

  // Called at a negedge; returns rvalid/rdata for the cycle after the strobe
  // and for the cycle after that.
  task automatic rd(input logic [2:0] a, output logic v1, output logic [31:0] d1,
                    output logic v2, output logic [31:0] d2);
    sel = 1'b1; addr = a; rstrb = 1'b1; wmask = 4'b0000;
    @(negedge xtal);
    v1 = rvalid; d1 = rdata;
    sel = 1'b0; rstrb = 1'b0;
    @(negedge xtal);
    v2 = rvalid; d2 = rdata;
  endtask

  task automatic test_reset();
    logic v1, v2;
    logic [31:0] d1, d2;
    resetn = 1'b0; sel = 1'b0; addr = '0; wdata = '0; wmask = '0; rstrb = 1'b0;
    #1;
    total++;
    if (gpio !== 16'h0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_async: gpio=%h rvalid=%b rdata=%h want 0/0/0", gpio, rvalid, rdata);
    end
    repeat (3) @(negedge xtal);
    resetn = 1'b1;
    @(negedge xtal);
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], v1, d1, v2, d2);
      total++;
      if (v1 !== 1'b1 || d1 !== 32'h0) begin
        bad++;
        $display("FAIL reset_read_%0d: rvalid=%b rdata=%h want 1/00000000", a, v1, d1);
      end
    end
  endtask

  task automatic test_bit_ops();
    logic [15:0] exp_v [4];
    logic [2:0]  a_v   [4];
    logic [31:0] d_v   [4];
    exp_v = '{16'h0005, 16'h0007, 16'h0006, 16'h000A};
    a_v   = '{3'd0, 3'd1, 3'd2, 3'd3};
    d_v   = '{32'h5, 32'h2, 32'h1, 32'hC};
    for (int i = 0; i < 4; i++) begin
      wr(a_v[i], d_v[i], 4'b1111);
      total++;
      if (gpio !== exp_v[i]) begin
        bad++;
        $display("FAIL bit_op_%0d: gpio=%h want %h", i, gpio, exp_v[i]);
      end
    end
    // No write without sel or with an empty byte mask.
    sel = 1'b0; addr = 3'd0; wdata = 32'hFFFF; wmask = 4'b1111;
    @(negedge xtal);
    wr(3'd0, 32'hFFFF, 4'b0000);
    wmask = 4'b0000;
    total++;
    if (gpio !== 16'h000A) begin
      bad++;
      $display("FAIL no_write: gpio=%h want 000a", gpio);
    end
  endtask

  task automatic test_byte_mask();
    wr(3'd0, 32'h0, 4'b1111);
    wr(3'd0, 32'hFFFFFFFF, 4'b0001);
    total++;
    if (gpio !== 16'h00FF) begin
      bad++;
      $display("FAIL byte_mask_lo: gpio=%h want 00ff", gpio);
    end
    wr(3'd2, 32'hFFFFFFFF, 4'b0010);
    wr(3'd1, 32'hAB00, 4'b0010);
    total++;
    if (gpio !== 16'hABFF) begin
      bad++;
      $display("FAIL byte_mask_hi: gpio=%h want abff", gpio);
    end
  endtask

  task automatic test_reads();
    logic v1, v2;
    logic [31:0] d1, d2;
    wr(3'd4, 32'h123, 4'b1111);
    rd(3'd4, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b1 || d1 !== 32'h00000123) begin
      bad++;
      $display("FAIL read_period: rvalid=%b rdata=%h want 1/00000123", v1, d1);
    end
    total++;
    if (v2 !== 1'b0 || d2 !== 32'h0) begin
      bad++;
      $display("FAIL read_pulse_end: rvalid=%b rdata=%h want 0/00000000", v2, d2);
    end
    wr(3'd4, 32'hFFFFFFFF, 4'b1111);
    rd(3'd4, v1, d1, v2, d2);
    total++;
    if (d1 !== 32'h00FFFFFF) begin
      bad++;
      $display("FAIL read_period_width: rdata=%h want 00ffffff", d1);
    end
    wr(3'd5, 32'hFFFFFFFF, 4'b1111);
    rd(3'd5, v1, d1, v2, d2);
    total++;
    if (d1 !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL read_mask_width: rdata=%h want 0000ffff", d1);
    end
    wr(3'd7, 32'hFFFFFFFF, 4'b1111);
    rd(3'd7, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b1 || d1 !== 32'h0) begin
      bad++;
      $display("FAIL read_reserved: rvalid=%b rdata=%h want 1/00000000", v1, d1);
    end
    rd(3'd1, v1, d1, v2, d2);
    total++;
    if (d1 !== 32'h0) begin
      bad++;
      $display("FAIL read_set_alias: rdata=%h want 00000000", d1);
    end
    // Same-cycle read and write of OUT returns the old value.
    wr(3'd0, 32'h1234, 4'b1111);
    sel = 1'b1; addr = 3'd0; wdata = 32'h5678; wmask = 4'b1111; rstrb = 1'b1;
    @(negedge xtal);
    sel = 1'b0; wmask = 4'b0000; rstrb = 1'b0;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h00001234 || gpio !== 16'h5678) begin
      bad++;
      $display("FAIL read_write_same: rvalid=%b rdata=%h gpio=%h want 1/00001234/5678", rvalid, rdata, gpio);
    end
    wr(3'd4, 32'h0, 4'b1111);
    wr(3'd5, 32'h0, 4'b1111);
  endtask

  task automatic test_blink();
    int toggles;
    int first_idx;
    int bad_gap;
    int last_idx;
    logic prev;
    wr(3'd0, 32'h0, 4'b1111);
    wr(3'd4, 32'd3, 4'b1111);
    wr(3'd5, 32'h1, 4'b1111);
    wr(3'd6, 32'h1, 4'b1111);
    @(negedge xtal);
    prev = gpio[0];
    toggles = 0; first_idx = -1; bad_gap = 0; last_idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge xtal);
      if (gpio[0] !== prev) begin
        toggles++;
        if (first_idx < 0) first_idx = i;
        if (last_idx >= 0 && i - last_idx != 4) bad_gap++;
        last_idx = i;
      end
      prev = gpio[0];
    end
    total++;
    if (toggles != 10) begin
      bad++;
      $display("FAIL blink_count: toggles=%0d want 10", toggles);
    end
    total++;
    if (first_idx != 3 || bad_gap != 0) begin
      bad++;
      $display("FAIL blink_spacing: first=%0d bad_gaps=%0d want 3/0", first_idx, bad_gap);
    end
    total++;
    if (gpio[15:1] !== 15'h0) begin
      bad++;
      $display("FAIL blink_mask: gpio=%h want only bit0 active", gpio);
    end
  endtask

  task automatic test_collision();
    int bad_hold;
    // Last toggle just happened; next cnt==0 edge is 4 edges away.
    repeat (3) @(negedge xtal);
    wr(3'd1, 32'h1, 4'b1111);
    total++;
    if (gpio !== 16'h0001) begin
      bad++;
      $display("FAIL collision_set: gpio=%h want 0001", gpio);
    end
    bad_hold = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge xtal);
      if (gpio !== 16'h0001) bad_hold++;
    end
    @(negedge xtal);
    total++;
    if (bad_hold != 0 || gpio !== 16'h0000) begin
      bad++;
      $display("FAIL collision_next_toggle: early_changes=%0d gpio=%h want 0/0000", bad_hold, gpio);
    end
    wr(3'd6, 32'h0, 4'b1111);
    bad_hold = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge xtal);
      if (gpio !== 16'h0000) bad_hold++;
    end
    total++;
    if (bad_hold != 0) begin
      bad++;
      $display("FAIL blink_stop: changes=%0d want 0", bad_hold);
    end
  endtask

  task automatic test_reset_mid();
    logic v1, v2;
    logic [31:0] d1, d2;
    int moved;
    wr(3'd0, 32'hA5A0, 4'b1111);
    wr(3'd4, 32'd3, 4'b1111);
    wr(3'd5, 32'hF, 4'b1111);
    wr(3'd6, 32'h1, 4'b1111);
    repeat (6) @(negedge xtal);
    sel = 1'b1; addr = 3'd6; rstrb = 1'b1;
    @(posedge xtal);
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (gpio !== 16'h0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: gpio=%h rvalid=%b rdata=%h want 0000/0/00000000", gpio, rvalid, rdata);
    end
    sel = 1'b0; rstrb = 1'b0;
    repeat (2) @(negedge xtal);
    resetn = 1'b1;
    moved = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge xtal);
      if (gpio !== 16'h0) moved++;
    end
    total++;
    if (moved != 0) begin
      bad++;
      $display("FAIL reset_no_blink: nonzero_cycles=%0d want 0", moved);
    end
    rd(3'd6, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b1 || d1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_ctrl_read: rvalid=%b rdata=%h want 1/00000000", v1, d1);
    end
    rd(3'd4, v1, d1, v2, d2);
    total++;
    if (d1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_period_read: rdata=%h want 00000000", d1);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_bit_ops();
    test_byte_mask();
    test_reads();
    test_blink();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
